// File: rtl/mem_port_arbiter_if.sv
// Bus bundle around the shared memory port arbiter.
// Carries the instruction-fetch requester, the load/store requester and the
// memory-side signals. The arbiter takes the slave view; the core datapath
// plus the memory together take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch (port 0)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // load/store (port 1)
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_be;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  // memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_addr, mem_wdata, mem_we, mem_be,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch (port 0) and
// load/store (port 1). One transaction outstanding at a time; the response is
// routed back to whichever port was granted.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise load/store always beats fetch.
//
// state     | meaning
// ST_IDLE   | nothing outstanding, arbitration open
// ST_WAIT   | memory access in flight, cnt_q counts down to 0
// ST_RESP   | memory data valid this cycle, arbitration open again
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // latency 1 goes straight to RESP and never uses the counter
  localparam logic [2:0] CNT_INIT = (MEM_LATENCY > 1) ? 3'(MEM_LATENCY - 2) : 3'd0;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
`ifdef MEM_ARB_RR_EN
  logic       last_q, last_d;
`endif

  logic arb_open;
  logic ls_wins_tie;
  logic grant_ls;
  logic grant_if;
  logic launch;
  logic resp_fire;

  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // arbitration: open in IDLE and RESP only while clocked and out of reset
  always_comb begin
    arb_open = ce && !reset && ((state_q == ST_IDLE) || (state_q == ST_RESP));
`ifdef MEM_ARB_RR_EN
    // the port that did not win last time takes the tie
    ls_wins_tie = (last_q == 1'b0);
`else
    ls_wins_tie = 1'b1;
`endif
    grant_ls  = arb_open && bus.ls_req && (!bus.if_req || ls_wins_tie);
    grant_if  = arb_open && bus.if_req && !grant_ls;
    launch    = grant_ls || grant_if;
    resp_fire = ce && !reset && (state_q == ST_RESP);
  end

  // memory request mux: only the winner of this cycle drives the port
  always_comb begin
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    bus.mem_we  = 1'b0;
    bus.mem_be  = 4'b0000;
    if (grant_ls) begin
      mem_addr_c  = bus.ls_addr;
      mem_wdata_c = bus.ls_wdata;
      bus.mem_we  = bus.ls_we;
      bus.mem_be  = bus.ls_be;
    end else if (grant_if) begin
      mem_addr_c  = bus.if_addr;
    end
    bus.mem_addr  = mem_addr_c;
    bus.mem_wdata = mem_wdata_c;
  end

  // requester handshake and response routing
  always_comb begin
    bus.if_gnt    = grant_if;
    bus.ls_gnt    = grant_ls;
    bus.if_rvalid = resp_fire && !owner_q;
    bus.ls_rvalid = resp_fire && owner_q;
    bus.if_rdata  = bus.mem_rdata;
    bus.ls_rdata  = bus.mem_rdata;
  end

  // next-state: everything holds while ce is low so a RESP is re-presented
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    if (ce) begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_WAIT: begin
          if (cnt_q == 3'd0) state_d = ST_RESP;
          else               cnt_d   = cnt_q - 3'd1;
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      // a grant in IDLE or RESP starts the next transaction
      if (launch) begin
        state_d = (MEM_LATENCY == 1) ? ST_RESP : ST_WAIT;
        cnt_d   = CNT_INIT;
        owner_d = grant_ls;
`ifdef MEM_ARB_RR_EN
        last_d  = grant_ls;
`endif
      end
    end
  end

  // state registers, synchronous reset drops any outstanding response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      owner_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

`ifndef SYNTHESIS
  // requesters must hold req until granted
  a_if_req_held: assert property (@(posedge clk) disable iff (reset)
    (bus.if_req && !bus.if_gnt) |=> bus.if_req);
  a_ls_req_held: assert property (@(posedge clk) disable iff (reset)
    (bus.ls_req && !bus.ls_gnt) |=> bus.ls_req);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with latency 1, one with
// latency 3, each with a small synchronous memory model sharing ce.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        ce;
    logic        ir;
    logic [31:0] ia;
    logic        lr;
    logic        lwe;
    logic [31:0] la;
    logic [31:0] lwd;
    logic [3:0]  lbe;
    logic        e_ig;
    logic        e_lg;
    logic        e_ir;
    logic        e_lr;
    logic        crd;
    logic [31:0] erd;
    logic        cma;
    logic [31:0] ema;
    logic        emwe;
    logic [3:0]  embe;
  } vec_t;

  logic clk = 1'b0;
  logic reset1, reset3, ce;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset1), .ce(ce), .bus(b1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .ce(ce), .bus(b3));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  // memory models: address captured at the grant edge, data after MEM_LATENCY ce cycles
  logic [31:0] a1_q;
  logic [31:0] a3_q [3];
  always @(posedge clk) if (ce) a1_q <= b1.mem_addr;
  always @(posedge clk) if (ce) begin
    a3_q[0] <= b3.mem_addr;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  always_comb b1.mem_rdata = mem_word(a1_q);
  always_comb b3.mem_rdata = mem_word(a3_q[2]);

  function automatic vec_t mk(
      input logic rst, input logic c, input logic ir, input logic [31:0] ia,
      input logic lr, input logic lwe, input logic [31:0] la, input logic [31:0] lwd,
      input logic [3:0] lbe, input logic eig, input logic elg, input logic eir,
      input logic elr, input logic crd, input logic [31:0] erd, input logic cma,
      input logic [31:0] ema, input logic emwe, input logic [3:0] embe);
    vec_t v;
    v.rst = rst; v.ce = c; v.ir = ir; v.ia = ia; v.lr = lr; v.lwe = lwe;
    v.la = la; v.lwd = lwd; v.lbe = lbe; v.e_ig = eig; v.e_lg = elg;
    v.e_ir = eir; v.e_lr = elr; v.crd = crd; v.erd = erd; v.cma = cma;
    v.ema = ema; v.emwe = emwe; v.embe = embe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input int which, input vec_t v, input string tag);
    logic o_ig, o_lg, o_ir, o_lr, o_mwe;
    logic [31:0] o_ird, o_lrd, o_ma, o_mwd;
    logic [3:0] o_mbe;
    ce = v.ce;
    if (which == 1) begin
      reset1 = v.rst; b1.if_req = v.ir; b1.if_addr = v.ia; b1.ls_req = v.lr;
      b1.ls_we = v.lwe; b1.ls_addr = v.la; b1.ls_wdata = v.lwd; b1.ls_be = v.lbe;
    end else begin
      reset3 = v.rst; b3.if_req = v.ir; b3.if_addr = v.ia; b3.ls_req = v.lr;
      b3.ls_we = v.lwe; b3.ls_addr = v.la; b3.ls_wdata = v.lwd; b3.ls_be = v.lbe;
    end
    @(negedge clk);
    if (which == 1) begin
      o_ig = b1.if_gnt; o_lg = b1.ls_gnt; o_ir = b1.if_rvalid; o_lr = b1.ls_rvalid;
      o_ird = b1.if_rdata; o_lrd = b1.ls_rdata; o_ma = b1.mem_addr;
      o_mwd = b1.mem_wdata; o_mwe = b1.mem_we; o_mbe = b1.mem_be;
    end else begin
      o_ig = b3.if_gnt; o_lg = b3.ls_gnt; o_ir = b3.if_rvalid; o_lr = b3.ls_rvalid;
      o_ird = b3.if_rdata; o_lrd = b3.ls_rdata; o_ma = b3.mem_addr;
      o_mwd = b3.mem_wdata; o_mwe = b3.mem_we; o_mbe = b3.mem_be;
    end
    chk({tag, " if_gnt"}, 32'(o_ig), 32'(v.e_ig));
    chk({tag, " ls_gnt"}, 32'(o_lg), 32'(v.e_lg));
    chk({tag, " if_rvalid"}, 32'(o_ir), 32'(v.e_ir));
    chk({tag, " ls_rvalid"}, 32'(o_lr), 32'(v.e_lr));
    chk({tag, " mem_we"}, 32'(o_mwe), 32'(v.emwe));
    chk({tag, " mem_be"}, 32'(o_mbe), 32'(v.embe));
    if (v.cma) begin
      chk({tag, " mem_addr"}, o_ma, v.ema);
      chk({tag, " mem_wdata"}, o_mwd, v.e_lg ? v.lwd : 32'h0);
    end
    if (v.crd && v.e_ir) chk({tag, " if_rdata"}, o_ird, v.erd);
    if (v.crd && v.e_lr) chk({tag, " ls_rdata"}, o_lrd, v.erd);
    @(posedge clk);
    #1;
  endtask

  vec_t t1 [16];
  vec_t t3 [16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        rst ce ir ia        lr lwe la        lwd           lbe   eig elg eir elr crd erd                   cma ema       we be
    t1[0]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               1, 32'h0,   0, 4'h0);
    t1[1]  = mk(0, 1, 1, 32'h100, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 0, 0, 32'h0,               1, 32'h100, 0, 4'h0);
    t1[2]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 1, 0, 1, 32'h00500093,        0, 32'h0,   0, 4'h0);
    t1[3]  = mk(0, 1, 1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, 0, 32'h0,               1, 32'h200, 1, 4'hF);
    t1[4]  = mk(0, 1, 1, 32'h104, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 1, 0, 32'h0,               1, 32'h104, 0, 4'h0);
    t1[5]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 1, 0, 1, mem_word(32'h104),   0, 32'h0,   0, 4'h0);
    t1[6]  = mk(0, 1, 1, 32'h108, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 0, 0, 32'h0,               1, 32'h108, 0, 4'h0);
    t1[7]  = mk(0, 1, 0, 32'h0,   1, 0, 32'h300, 32'h0,        4'hF, 0, 1, 1, 0, 1, mem_word(32'h108),   1, 32'h300, 0, 4'hF);
    t1[8]  = mk(0, 1, 1, 32'h10C, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 1, 1, mem_word(32'h300),   1, 32'h10C, 0, 4'h0);
    t1[9]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 1, 0, 1, mem_word(32'h10C),   0, 32'h0,   0, 4'h0);
    t1[10] = mk(0, 1, 0, 32'h0,   1, 0, 32'h400, 32'h0,        4'hF, 0, 1, 0, 0, 0, 32'h0,               1, 32'h400, 0, 4'hF);
    t1[11] = mk(0, 0, 1, 32'h110, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               0, 32'h0,   0, 4'h0);
    t1[12] = mk(0, 0, 1, 32'h110, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               0, 32'h0,   0, 4'h0);
    t1[13] = mk(0, 1, 1, 32'h110, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 1, 1, mem_word(32'h400),   1, 32'h110, 0, 4'h0);
    t1[14] = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 1, 0, 1, mem_word(32'h110),   0, 32'h0,   0, 4'h0);
    t1[15] = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               1, 32'h0,   0, 4'h0);

    // latency 3: load, then a fetch that must wait for the response cycle
    t3[0]  = mk(0, 1, 0, 32'h0,   1, 0, 32'h500, 32'h0,        4'hF, 0, 1, 0, 0, 0, 32'h0,               1, 32'h500, 0, 4'hF);
    t3[1]  = mk(0, 1, 1, 32'h120, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               0, 32'h0,   0, 4'h0);
    t3[2]  = mk(0, 1, 1, 32'h120, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               0, 32'h0,   0, 4'h0);
    t3[3]  = mk(0, 1, 1, 32'h120, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 1, 1, mem_word(32'h500),   1, 32'h120, 0, 4'h0);
    t3[4]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               0, 32'h0,   0, 4'h0);
    t3[5]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               0, 32'h0,   0, 4'h0);
    t3[6]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 1, 0, 1, mem_word(32'h120),   0, 32'h0,   0, 4'h0);
    t3[7]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               1, 32'h0,   0, 4'h0);
    // latency 3: reset while the fetch of 0x130 is in flight
    t3[8]  = mk(0, 1, 1, 32'h130, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 0, 0, 32'h0,               1, 32'h130, 0, 4'h0);
    t3[9]  = mk(1, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               1, 32'h0,   0, 4'h0);
    t3[10] = mk(1, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               1, 32'h0,   0, 4'h0);
    t3[11] = mk(0, 1, 1, 32'h140, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 0, 0, 32'h0,               1, 32'h140, 0, 4'h0);
    t3[12] = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               0, 32'h0,   0, 4'h0);
    t3[13] = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               0, 32'h0,   0, 4'h0);
    t3[14] = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 1, 0, 1, mem_word(32'h140),   0, 32'h0,   0, 4'h0);
    t3[15] = mk(0, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,               1, 32'h0,   0, 4'h0);

    reset1 = 1'b1; reset3 = 1'b1; ce = 1'b1;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.ls_req = 1'b0; b1.ls_we = 1'b0;
    b1.ls_addr = '0; b1.ls_wdata = '0; b1.ls_be = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.ls_req = 1'b0; b3.ls_we = 1'b0;
    b3.ls_addr = '0; b3.ls_wdata = '0; b3.ls_be = '0;
    repeat (3) @(posedge clk);
    #1;
    reset1 = 1'b0; reset3 = 1'b0;

    for (int i = 0; i < 16; i++) apply(1, t1[i], $sformatf("lat1[%0d]", i));
    for (int i = 0; i < 16; i++) apply(3, t3[i], $sformatf("lat3[%0d]", i));

    // both ports held busy; grants alternate in round-robin builds, LS wins otherwise
    begin
      logic        exp_ls, prev_ls;
      logic [31:0] prev_a;
      vec_t v;
      prev_ls = 1'b0;
      prev_a  = 32'h0;
      for (int k = 0; k < 7; k++) begin
        exp_ls = RR ? (k % 2 == 0) : 1'b1;
        v = mk(0, 1, 1, 32'h700, 1, 0, 32'h800, 32'h0, 4'hF,
               !exp_ls, exp_ls, (k > 0) && !prev_ls, (k > 0) && prev_ls,
               k > 0, mem_word(prev_a), 1, exp_ls ? 32'h800 : 32'h700,
               0, exp_ls ? 4'hF : 4'h0);
        apply(1, v, $sformatf("tie[%0d]", k));
        prev_ls = exp_ls;
        prev_a  = exp_ls ? 32'h800 : 32'h700;
      end
      apply(1, mk(0, 1, 1, 32'h700, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 1, 1,
                  mem_word(32'h800), 1, 32'h700, 0, 4'h0), "tie_tail0");
      apply(1, mk(0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 1, 0, 1,
                  mem_word(32'h700), 0, 32'h0, 0, 4'h0), "tie_tail1");
      apply(1, mk(0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                  32'h0, 1, 32'h0, 0, 4'h0), "tie_tail2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
